hazard_ctrl: RTL

- Central pipeline controller for the 5-stage RISC-V core.
- Drives stall/flush into the fetch/decode, decode/execute and execute/memory pipeline registers, plus the PC enable.
- Arbitrates between four hazard sources:
  - load-use data hazard
  - taken branch/jump redirect resolved in EX
  - multi-cycle multiply/divide occupancy of EX
  - instruction-memory wait
- Keeps a saturating count of front-end stall cycles for performance monitoring.

---
 rtl/hazard_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: arbitrates mul/div occupancy, EX redirects, load-use
// hazards and instruction-memory wait into stall/flush controls and a stall counter.
module hazard_ctrl #(
  parameter int MDU_CYCLES  = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_redirect,
  input  logic                   ex_mdu_start,
  input  logic                   imem_ready,
  output logic                   pc_en,
  output logic                   fd_stall,
  output logic                   fd_flush,
  output logic                   de_stall,
  output logic                   de_flush,
  output logic                   em_flush,
  output logic                   mdu_busy,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] REM_INIT = 4'(MDU_CYCLES - 1);

  state_t                 r_state;
  logic [3:0]             r_rem;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   w_mdu_stall;
  logic                   w_load_use;

  always_comb begin
    w_load_use = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                  (id_uses_rs2 && (id_rs2 == ex_rd)));
    // In BUSY the held op keeps ex_mdu_start high, so only rem decides the stall.
    w_mdu_stall = (r_state == BUSY) ? (r_rem > 4'd1)
                                    : (ex_mdu_start && (MDU_CYCLES > 1));
  end

  // NOTE: every output gets a default first so no path through the chain infers a latch.
  always_comb begin
    pc_en    = 1'b1;
    fd_stall = 1'b0;
    fd_flush = 1'b0;
    de_stall = 1'b0;
    de_flush = 1'b0;
    em_flush = 1'b0;
    if (rst) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      em_flush = 1'b1;
    end else if (w_mdu_stall) begin
      pc_en    = 1'b0;
      fd_stall = 1'b1;
      de_stall = 1'b1;
      em_flush = 1'b1;
    end else if (ex_redirect) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en    = 1'b0;
      fd_stall = 1'b1;
      de_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_en    = 1'b0;
      fd_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_rem          <= 4'd0;
      r_stall_cycles <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ex_mdu_start && (MDU_CYCLES > 1)) begin
            r_rem   <= REM_INIT;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_rem <= r_rem - 4'd1;
          if (r_rem <= 4'd1) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
      if (!pc_en && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign mdu_busy     = (r_state == BUSY);
  assign stall_cycles = r_stall_cycles;

endmodule
